// File: rtl/dac_write_pkg.sv
// Sample conversion helpers shared by the multi-channel DAC write path.
// Pure combinational functions, no latency of their own.
// No flow control; callers truncate the wide results to the DAC code width.
package dac_write_pkg;

    localparam int MAXW = 64;
    typedef logic signed [MAXW-1:0] wide_t;

    // Sign-extend an IW-bit sample held in the low bits of raw; offset binary flips the MSB first.
    function automatic wide_t f_decode(input logic [MAXW-1:0] raw, input int iw, input bit twos);
        logic [MAXW-1:0] v;
        v = raw << (MAXW - iw);
        if (!twos)
            v = v ^ (MAXW'(1) << (MAXW - 1));
        return wide_t'(v) >>> (MAXW - iw);
    endfunction

    function automatic wide_t f_round_sat(input wide_t x, input int iw, input int dw);
        wide_t y;
        wide_t vmax;
        wide_t vmin;
        y    = x;
        vmax = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
        vmin = -(wide_t'(1) <<< (dw - 1));
        if (iw > dw)
            y = (y + (wide_t'(1) <<< (iw - dw - 1))) >>> (iw - dw);
        if (y > vmax)
            y = vmax;
        else if (y < vmin)
            y = vmin;
        return y;
    endfunction

    function automatic wide_t f_invert_sat(input wide_t x, input int dw);
        wide_t vmin;
        vmin = -(wide_t'(1) <<< (dw - 1));
        if (x == vmin)
            return (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
        return -x;
    endfunction

    function automatic logic [MAXW-1:0] f_encode(input wide_t x, input int dw, input bit ob);
        logic [MAXW-1:0] v;
        v = x;
        if (ob)
            v = v ^ (MAXW'(1) << (dw - 1));
        return v;
    endfunction

    function automatic logic [MAXW-1:0] f_midscale(input int dw, input bit ob);
        return ob ? (MAXW'(1) << (dw - 1)) : '0;
    endfunction

endpackage

// File: rtl/dac_write_fifo.sv
// Synchronous per-channel sample FIFO with registered occupancy count.
// Read data is the combinational head; a pushed word is visible the cycle after the push.
// Pushes are dropped while full (even with a same-cycle pop); pops are ignored while empty.
module dac_write_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/dac_write_mc.sv
// Buffers CH sample streams, converts each to a DAC code and interleaves them one slot per cycle.
// Output register adds one cycle after the slot's pop; a sample pushed one edge is poppable the next cycle.
// in_ready per channel is FIFO-not-full; a starved slot repeats its last code (or mid-scale) and flags underflow.
module dac_write_mc
    import dac_write_pkg::*;
#(
    parameter int INT_CHANNELS            = 2,
    parameter int INT_IDATA_WIDTH         = 16,
    parameter int INT_DAC_DATA_WIDTH      = 14,
    parameter int INT_FIFO_DEPTH          = 4,
    parameter int INT_IDATA_ENC_TWOSCOMPL = 1,
    parameter int INT_ODATA_ENC_OFFSETBIN = 1,
    parameter int INT_INVERT_ODATA        = 0,
    parameter int INT_UNDERFLOW_HOLD      = 1,
    localparam int SW = (INT_CHANNELS > 1) ? $clog2(INT_CHANNELS) : 1
) (
    input  logic                                    in_clk,
    input  logic                                    in_rst_n,
    input  logic [INT_CHANNELS-1:0]                 in_valid,
    output logic [INT_CHANNELS-1:0]                 in_ready,
    input  logic [INT_CHANNELS*INT_IDATA_WIDTH-1:0] in_data,
    input  logic                                    in_enable,
    input  logic                                    in_clear_flags,
    output logic [INT_DAC_DATA_WIDTH-1:0]           out_data,
    output logic [SW-1:0]                           out_sel,
    output logic                                    out_wrt,
    output logic [INT_CHANNELS-1:0]                 out_underflow
);
    localparam int CH = INT_CHANNELS;
    localparam int IW = INT_IDATA_WIDTH;
    localparam int DW = INT_DAC_DATA_WIDTH;
    localparam logic [DW-1:0] MID = DW'(f_midscale(DW, INT_ODATA_ENC_OFFSETBIN != 0));

    logic [SW-1:0]   slot;
    logic            rdy_q;
    logic [CH-1:0]   full;
    logic [CH-1:0]   empty;
    logic [CH-1:0]   pop;
    logic [CH-1:0]   uf_set;
    logic [IW-1:0]   head [CH];
    logic [DW-1:0]   hold [CH];
    logic [IW-1:0]   head_sel;
    logic [DW-1:0]   hold_sel;
    logic            uf_sel;
    logic [DW-1:0]   conv;
    logic [DW-1:0]   code;
    wide_t           rs;
    wide_t           inv;

    for (genvar k = 0; k < CH; k++) begin : g_ch
        dac_write_fifo #(
            .DEPTH (INT_FIFO_DEPTH),
            .WIDTH (IW)
        ) u_fifo (
            .clk     (in_clk),
            .rst_n   (in_rst_n),
            .push    (in_valid[k] && in_ready[k]),
            .pop     (pop[k]),
            .wr_data (in_data[k*IW +: IW]),
            .rd_data (head[k]),
            .full    (full[k]),
            .empty   (empty[k])
        );
        assign in_ready[k] = rdy_q && !full[k];
        assign pop[k]      = in_enable && (slot == SW'(k)) && !empty[k];
        assign uf_set[k]   = in_enable && (slot == SW'(k)) && empty[k];
    end

    always_comb begin
        head_sel = '0;
        hold_sel = MID;
        uf_sel   = 1'b0;
        for (int k = 0; k < CH; k++) begin
            if (slot == SW'(k)) begin
                head_sel = head[k];
                hold_sel = hold[k];
                uf_sel   = empty[k];
            end
        end
    end

    always_comb begin
        rs   = f_round_sat(f_decode(MAXW'(head_sel), IW, INT_IDATA_ENC_TWOSCOMPL != 0), IW, DW);
        inv  = (INT_INVERT_ODATA != 0) ? f_invert_sat(rs, DW) : rs;
        conv = DW'(f_encode(inv, DW, INT_ODATA_ENC_OFFSETBIN != 0));
        if (uf_sel)
            code = (INT_UNDERFLOW_HOLD != 0) ? hold_sel : MID;
        else
            code = conv;
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            slot          <= '0;
            rdy_q         <= 1'b0;
            out_data      <= MID;
            out_sel       <= '0;
            out_wrt       <= 1'b0;
            out_underflow <= '0;
            for (int k = 0; k < CH; k++)
                hold[k] <= MID;
        end else begin
            rdy_q         <= 1'b1;
            // A fresh underflow outranks a same-cycle clear.
            out_underflow <= (out_underflow & ~{CH{in_clear_flags}}) | uf_set;
            if (in_enable) begin
                slot     <= (slot == SW'(CH-1)) ? '0 : slot + 1'b1;
                out_data <= code;
                out_sel  <= slot;
                out_wrt  <= 1'b1;
                for (int k = 0; k < CH; k++)
                    if (slot == SW'(k))
                        hold[k] <= code;
            end else begin
                slot     <= '0;
                out_data <= MID;
                out_wrt  <= 1'b0;
            end
        end
    end

endmodule
